// File: rtl/piso_serial_pkg.sv
// Shared types and constants for the framed serial transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package piso_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Level driven on the line between frames and during the stop bit.
  localparam logic LINE_IDLE = 1'b1;
  // Level of the start bit that marks the beginning of a frame.
  localparam logic START_BIT = 1'b0;

  // Ceiling log2; returns 0 for an argument of 1, so callers clamp to 1 bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_serial_tx_if.sv
// Parallel load handshake plus serial line and status for the transmitter.
// Latency: n/a (wires only).
// Backpressure: load is honoured only while ready is high.
// Ports: data_in/load from the word source; ready/tx/busy/done from the transmitter.
interface piso_serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              load;
  logic              ready;
  logic              tx;
  logic              busy;
  logic              done;

  // Word source side.
  modport master (
    output data_in,
    output load,
    input  ready,
    input  tx,
    input  busy,
    input  done
  );

  // Transmitter side.
  modport slave (
    input  data_in,
    input  load,
    output ready,
    output tx,
    output busy,
    output done
  );
endinterface

// File: rtl/piso_serial_tx_bit_period_counter.sv
// Divides clk into serial bit periods, ticking on the last cycle of each.
// Latency: tick is a decode of the registered count (no input-to-output path).
// Backpressure: none; clear holds the count at zero.
// Ports: clk, reset (async active-low), clear (hold at 0), tick (last cycle of period).
module bit_period_counter
  import piso_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (clog2(CLKS_PER_BIT) < 1) ? 1 : clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // With CLKS_PER_BIT=1, LAST is 0 and every cycle is a bit boundary.
  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/piso_serial_tx.sv
// Frames a parallel word as start bit, data LSB-first, stop bit on one serial line.
// Latency: first start-bit cycle follows the accept edge; frame is (DATA_W+2)*CLKS_PER_BIT cycles.
// Backpressure: ready is high only in IDLE; loads while busy are ignored.
// Ports: clk, reset (async active-low), bus (slave side of piso_serial_tx_if).
module piso_serial_tx
  import piso_serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  piso_serial_tx_if.slave      bus
);

  localparam int BW = clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  // Assertion of reset passes straight through; release is delayed two edges
  // so the FSM never leaves reset on a metastable sample.
  logic [1:0] rst_sync;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync[1];

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] shift_reg;
  logic [BW-1:0]     bit_idx;
  logic              done_q;
  logic              tick;
  logic              tx_d;
  logic              busy_d;
  logic              ready_d;

  bit_period_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_period (
    .clk   (clk),
    .reset (rst_n_int),
    .clear (state == IDLE),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.load) state_nxt = START;
      START:   if (tick) state_nxt = DATA;
      DATA:    if (tick && (bit_idx == LAST_BIT)) state_nxt = STOP;
      STOP:    if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    tx_d    = LINE_IDLE;
    busy_d  = 1'b1;
    ready_d = 1'b0;
    case (state)
      IDLE: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
      START:   tx_d = START_BIT;
      DATA:    tx_d = shift_reg[0];
      default: tx_d = LINE_IDLE;
    endcase
  end

  // Shift register, bit index and the done pulse.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      shift_reg <= '0;
      bit_idx   <= '0;
      done_q    <= 1'b0;
    end else begin
      // Lands on the first IDLE cycle, where a new load can also be accepted.
      done_q <= (state == STOP) && tick;
      case (state)
        IDLE: begin
          if (bus.load) shift_reg <= bus.data_in;
        end
        DATA: begin
          if (tick) begin
            shift_reg <= shift_reg >> 1;
            bit_idx   <= (bit_idx == LAST_BIT) ? '0 : bit_idx + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.tx    = tx_d;
  assign bus.busy  = busy_d;
  assign bus.ready = ready_d;
  assign bus.done  = done_q;

endmodule
